// File: rtl/ula_pkg.sv
// Shared definitions for ula_sequencial: opcodes, FSM states, flag positions
// and the active-low 7-segment glyphs (segments abcdefg, MSB = a).
package ula_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_DIV = 3'b111;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        CALC   = 2'd1,
        FIM    = 2'd2
    } estado_t;

    localparam int FLAG_NEG   = 3;
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 0;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;
    localparam logic [6:0] SEG_APAGADO = 7'b1111111;

    function automatic logic [6:0] glifo_hex(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ula_sequencial_if.sv
// Operand/result handshake bundle between the switch/key side (master)
// and the ALU (slave).
interface ula_sequencial_if #(
    parameter int LARGURA = 8
);
    logic               start;
    logic [2:0]         sel;
    logic [LARGURA-1:0] numum;
    logic [LARGURA-1:0] numdois;
    logic               usa_acc;
    logic               ocupado;
    logic               pronto;
    logic [LARGURA-1:0] resultado;
    logic [LARGURA-1:0] resto;
    logic [3:0]         flags;
    logic               erro;

    modport master (
        output start, sel, numum, numdois, usa_acc,
        input  ocupado, pronto, resultado, resto, flags, erro
    );

    modport slave (
        input  start, sel, numum, numdois, usa_acc,
        output ocupado, pronto, resultado, resto, flags, erro
    );
endinterface

// File: rtl/ula_sequencial_decodificador_hex.sv
// One active-low hex digit: nibble to segments abcdefg, or all segments off
// when apaga is set.
module decodificador_hex
    import ula_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       apaga,
    output logic [6:0] seg
);

    always_comb begin
        seg = apaga ? SEG_APAGADO : glifo_hex(nibble);
    end

endmodule

// File: rtl/ula_sequencial.sv
// Sequential ALU: start/done handshake, iterative MUL/DIV, registered result
// and flags, NUM_DIGITOS hex displays. Optional accumulator: ULA_ACUMULADOR_EN.
module ula_sequencial
    import ula_pkg::*;
#(
    parameter int LARGURA     = 8,
    parameter int NUM_DIGITOS = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    ula_sequencial_if.slave          bus,
    output logic [7*NUM_DIGITOS-1:0] HEX
);

    localparam int              CW     = $clog2(LARGURA + 1);
    localparam logic [CW-1:0]   ULTIMO = CW'(LARGURA - 1);

    estado_t            estado_q, estado_d;
    logic [2:0]         sel_q, sel_d;
    logic [LARGURA-1:0] op_a_q, op_a_d;
    logic [LARGURA-1:0] op_b_q, op_b_d;
    logic [LARGURA-1:0] hi_q, hi_d;
    logic [LARGURA-1:0] lo_q, lo_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [LARGURA-1:0] res_q, res_d;
    logic [LARGURA-1:0] resto_q, resto_d;
    logic [3:0]         flags_q, flags_d;
    logic               erro_q, erro_d;
    logic               pronto_q, pronto_d;
    logic               ocupado_q, ocupado_d;
    logic               valido_q, valido_d;

    logic [LARGURA-1:0] operando_a;

    logic [LARGURA:0]   soma, dif, soma_mul, deslocado;
    logic [LARGURA-1:0] mul_hi, mul_lo, div_rem, div_quo, div_sub;
    logic               div_ge;

    logic [LARGURA-1:0] res_calc, resto_calc;
    logic [3:0]         flags_calc;
    logic               carry_calc, ovf_calc, erro_calc;

`ifdef ULA_ACUMULADOR_EN
    logic [LARGURA-1:0] acc_q, acc_d;

    assign operando_a = bus.usa_acc ? acc_q : bus.numum;

    always_comb begin
        acc_d = (estado_q == FIM) ? res_d : acc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end
`else
    assign operando_a = bus.numum;
`endif

    // One iteration of shift-add multiply (hi:lo holds partial product and
    // remaining multiplier) and of restoring divide (hi = remainder, lo = quotient).
    always_comb begin
        soma      = {1'b0, op_a_q} + {1'b0, op_b_q};
        dif       = {1'b0, op_a_q} - {1'b0, op_b_q};
        soma_mul  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? op_b_q : '0)};
        mul_hi    = soma_mul[LARGURA:1];
        mul_lo    = {soma_mul[0], lo_q[LARGURA-1:1]};
        deslocado = {hi_q, lo_q[LARGURA-1]};
        div_ge    = deslocado >= {1'b0, op_b_q};
        div_sub   = deslocado[LARGURA-1:0] - op_b_q;
        div_rem   = div_ge ? div_sub : deslocado[LARGURA-1:0];
        div_quo   = {lo_q[LARGURA-2:0], div_ge};
    end

    // NOTE: every combinational output gets a default first so no path can
    // infer a latch.
    always_comb begin
        res_calc   = '0;
        resto_calc = '0;
        carry_calc = 1'b0;
        ovf_calc   = 1'b0;
        erro_calc  = 1'b0;
        case (sel_q)
            OP_AND: res_calc = op_a_q & op_b_q;
            OP_OR:  res_calc = op_a_q | op_b_q;
            OP_ADD: begin
                res_calc   = soma[LARGURA-1:0];
                carry_calc = soma[LARGURA];
                ovf_calc   = (op_a_q[LARGURA-1] == op_b_q[LARGURA-1]) &&
                             (soma[LARGURA-1] != op_a_q[LARGURA-1]);
            end
            OP_SUB: begin
                res_calc   = dif[LARGURA-1:0];
                carry_calc = dif[LARGURA];
                ovf_calc   = (op_a_q[LARGURA-1] != op_b_q[LARGURA-1]) &&
                             (dif[LARGURA-1] != op_a_q[LARGURA-1]);
            end
            OP_SHL: begin
                res_calc   = {op_a_q[LARGURA-2:0], 1'b0};
                carry_calc = op_a_q[LARGURA-1];
            end
            OP_SHR: begin
                res_calc   = {1'b0, op_a_q[LARGURA-1:1]};
                carry_calc = op_a_q[0];
            end
            OP_MUL: begin
                res_calc   = lo_q;
                carry_calc = |hi_q;
            end
            default: begin
                if (op_b_q == '0) begin
                    res_calc   = '1;
                    resto_calc = op_a_q;
                    erro_calc  = 1'b1;
                end else begin
                    res_calc   = lo_q;
                    resto_calc = hi_q;
                end
            end
        endcase
        flags_calc             = '0;
        flags_calc[FLAG_NEG]   = res_calc[LARGURA-1];
        flags_calc[FLAG_ZERO]  = (res_calc == '0);
        flags_calc[FLAG_CARRY] = carry_calc;
        flags_calc[FLAG_OVF]   = ovf_calc;
    end

    always_comb begin
        estado_d  = estado_q;
        sel_d     = sel_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        resto_d   = resto_q;
        flags_d   = flags_q;
        erro_d    = erro_q;
        valido_d  = valido_q;
        pronto_d  = 1'b0;
        ocupado_d = (estado_q != OCIOSO);
        case (estado_q)
            OCIOSO: begin
                // A start landing in the pronto cycle is dropped, not queued.
                if (bus.start && !pronto_q) begin
                    sel_d  = bus.sel;
                    op_a_d = operando_a;
                    op_b_d = bus.numdois;
                    hi_d   = '0;
                    lo_d   = operando_a;
                    cnt_d  = '0;
                    if (bus.sel == OP_MUL || (bus.sel == OP_DIV && bus.numdois != '0))
                        estado_d = CALC;
                    else
                        estado_d = FIM;
                end
            end
            CALC: begin
                if (sel_q == OP_MUL) begin
                    hi_d = mul_hi;
                    lo_d = mul_lo;
                end else begin
                    hi_d = div_rem;
                    lo_d = div_quo;
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == ULTIMO) estado_d = FIM;
            end
            FIM: begin
                res_d    = res_calc;
                resto_d  = resto_calc;
                flags_d  = flags_calc;
                erro_d   = erro_calc;
                valido_d = 1'b1;
                pronto_d = 1'b1;
                estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q  <= OCIOSO;
            sel_q     <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            res_q     <= '0;
            resto_q   <= '0;
            flags_q   <= '0;
            erro_q    <= 1'b0;
            pronto_q  <= 1'b0;
            ocupado_q <= 1'b0;
            valido_q  <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            sel_q     <= sel_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            resto_q   <= resto_d;
            flags_q   <= flags_d;
            erro_q    <= erro_d;
            pronto_q  <= pronto_d;
            ocupado_q <= ocupado_d;
            valido_q  <= valido_d;
        end
    end

    assign bus.ocupado   = ocupado_q;
    assign bus.pronto    = pronto_q;
    assign bus.resultado = res_q;
    assign bus.resto     = resto_q;
    assign bus.flags     = flags_q;
    assign bus.erro      = erro_q;

    // Upper digits stay blank until the first result has been produced.
    for (genvar i = 0; i < NUM_DIGITOS; i++) begin : g_digito
        logic [3:0] nibble;
        logic       apaga;
        if (i < LARGURA / 4) begin : g_ativo
            always_comb begin
                nibble = (erro_q && i == 0) ? 4'hE : res_q[4*i +: 4];
                apaga  = (i != 0) && (erro_q || !valido_q);
            end
        end else begin : g_vazio
            assign nibble = 4'h0;
            assign apaga  = 1'b1;
        end
        decodificador_hex u_dec (
            .nibble (nibble),
            .apaga  (apaga),
            .seg    (HEX[7*i +: 7])
        );
    end

endmodule

// File: tb/tb_ula_sequencial.sv
// Directed bench for ula_sequencial (LARGURA=8, two digits): vector table plus
// hand sequences for busy-ignore, pronto-cycle start, reset mid-MUL, accumulator.
module tb_ula_sequencial;

    localparam int W = 8;

    localparam logic [2:0] T_AND = 3'b000, T_OR  = 3'b001, T_ADD = 3'b010, T_SUB = 3'b011;
    localparam logic [2:0] T_SHL = 3'b100, T_SHR = 3'b101, T_MUL = 3'b110, T_DIV = 3'b111;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] hex;

    ula_sequencial_if #(.LARGURA(W)) bus ();

    ula_sequencial #(.LARGURA(W), .NUM_DIGITOS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .HEX   (hex)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        string      nome;
        logic [2:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [7:0] resto;
        logic [3:0] flags;
        logic       erro;
        int         lat;
    } vec_t;

    vec_t tab[13];

    function automatic logic [6:0] glifo(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b0000001;  4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;  4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;  4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;  4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;  4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;  4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;  4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;  default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    function automatic logic [13:0] hex_esperado(input logic [7:0] r, input logic e);
        logic [13:0] h;
        if (e) h = {BLANK, glifo(4'hE)};
        else   h = {glifo(r[7:4]), glifo(r[3:0])};
        return h;
    endfunction

    task automatic check(input string nome, input logic [31:0] real_v, input logic [31:0] esp);
        n_total++;
        if (real_v === esp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nome, real_v, esp);
    endtask

    // Start at edge N; returns k such that pronto is seen just after edge N+k.
    task automatic run_op(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                          input logic acc, output int lat);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.sel     = sel;
        bus.numum   = a;
        bus.numdois = b;
        bus.usa_acc = acc;
        @(posedge clk);
        @(negedge clk);
        bus.start   = 1'b0;
        bus.usa_acc = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.pronto) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) check("pronto_timeout", bus.pronto, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ocupado"}, bus.ocupado, 0);
        check({tag, "_pronto"}, bus.pronto, 0);
        check({tag, "_resultado"}, bus.resultado, 0);
        check({tag, "_resto"}, bus.resto, 0);
        check({tag, "_flags"}, bus.flags, 0);
        check({tag, "_erro"}, bus.erro, 0);
        check({tag, "_hex"}, hex, {BLANK, glifo(4'h0)});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        int n_pronto;

        tab[0]  = '{"add_7f_01",  T_ADD, 8'h7F, 8'h01, 8'h80, 8'h00, 4'b1001, 1'b0, 1};
        tab[1]  = '{"sub_03_05",  T_SUB, 8'h03, 8'h05, 8'hFE, 8'h00, 4'b1010, 1'b0, 1};
        tab[2]  = '{"shl_81",     T_SHL, 8'h81, 8'h00, 8'h02, 8'h00, 4'b0010, 1'b0, 1};
        tab[3]  = '{"and_f0_3c",  T_AND, 8'hF0, 8'h3C, 8'h30, 8'h00, 4'b0000, 1'b0, 1};
        tab[4]  = '{"or_zero",    T_OR,  8'h00, 8'h00, 8'h00, 8'h00, 4'b0100, 1'b0, 1};
        tab[5]  = '{"shr_01",     T_SHR, 8'h01, 8'h00, 8'h00, 8'h00, 4'b0110, 1'b0, 1};
        tab[6]  = '{"add_ff_01",  T_ADD, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b0110, 1'b0, 1};
        tab[7]  = '{"sub_80_01",  T_SUB, 8'h80, 8'h01, 8'h7F, 8'h00, 4'b0001, 1'b0, 1};
        tab[8]  = '{"mul_10_11",  T_MUL, 8'h10, 8'h11, 8'h10, 8'h00, 4'b0010, 1'b0, 9};
        tab[9]  = '{"mul_0c_0d",  T_MUL, 8'h0C, 8'h0D, 8'h9C, 8'h00, 4'b1000, 1'b0, 9};
        tab[10] = '{"div_200_7",  T_DIV, 8'd200, 8'd7, 8'd28, 8'd4,  4'b0000, 1'b0, 9};
        tab[11] = '{"div_5_0",    T_DIV, 8'd5,  8'd0,  8'hFF, 8'd5,  4'b1000, 1'b1, 1};
        tab[12] = '{"div_7_9",    T_DIV, 8'd7,  8'd9,  8'h00, 8'd7,  4'b0100, 1'b0, 9};

        bus.start = 1'b0; bus.sel = '0; bus.numum = '0; bus.numdois = '0; bus.usa_acc = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op(tab[i].sel, tab[i].a, tab[i].b, 1'b0, lat);
            check({tab[i].nome, "_lat"}, lat, tab[i].lat);
            check({tab[i].nome, "_res"}, bus.resultado, tab[i].res);
            check({tab[i].nome, "_resto"}, bus.resto, tab[i].resto);
            check({tab[i].nome, "_flags"}, bus.flags, tab[i].flags);
            check({tab[i].nome, "_erro"}, bus.erro, tab[i].erro);
            check({tab[i].nome, "_hex"}, hex, hex_esperado(tab[i].res, tab[i].erro));
            check({tab[i].nome, "_ocupado"}, bus.ocupado, 1);
            @(negedge clk);
            check({tab[i].nome, "_pronto_pulse"}, bus.pronto, 0);
            check({tab[i].nome, "_ocupado_end"}, bus.ocupado, 0);
        end

        // MUL with a second start pulsed at N+4 while busy.
        @(negedge clk);
        bus.start = 1'b1; bus.sel = T_MUL; bus.numum = 8'h10; bus.numdois = 8'h11;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        check("busy_ocupado", bus.ocupado, 1);
        bus.start = 1'b1; bus.sel = T_ADD; bus.numum = 8'h01; bus.numdois = 8'h01;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat = -1;
        for (int k = 5; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.pronto) begin lat = k; break; end
        end
        check("busy_mul_lat", lat, 9);
        check("busy_mul_res", bus.resultado, 8'h10);
        check("busy_mul_carry", bus.flags, 4'b0010);
        n_pronto = 0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.pronto) n_pronto++;
        end
        check("busy_no_queue", n_pronto, 0);

        // start held through the pronto cycle: ignored there, accepted next cycle.
        run_op(T_ADD, 8'h01, 8'h01, 1'b0, lat);
        check("pc_first_res", bus.resultado, 8'h02);
        bus.start = 1'b1; bus.sel = T_ADD; bus.numum = 8'h02; bus.numdois = 8'h02;
        @(posedge clk);
        @(negedge clk);
        check("pc_ignored_pronto", bus.pronto, 0);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("pc_accept_pronto_early", bus.pronto, 0);
        @(posedge clk);
        @(negedge clk);
        check("pc_accept_pronto", bus.pronto, 1);
        check("pc_accept_res", bus.resultado, 8'h04);

        // Asynchronous reset during CALC (cycle 3 of a MUL).
        @(negedge clk);
        bus.start = 1'b1; bus.sel = T_MUL; bus.numum = 8'h0C; bus.numdois = 8'h0D;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midmul");
        @(negedge clk);
        rst_n = 1'b1;
        run_op(T_ADD, 8'h7F, 8'h01, 1'b0, lat);
        check("after_rst_lat", lat, 1);
        check("after_rst_res", bus.resultado, 8'h80);
        check("after_rst_hex", hex, {glifo(4'h8), glifo(4'h0)});

`ifdef ULA_ACUMULADOR_EN
        run_op(T_ADD, 8'd5, 8'd3, 1'b0, lat);
        check("acc_load_res", bus.resultado, 8'h08);
        run_op(T_ADD, 8'h20, 8'd2, 1'b1, lat);
        check("acc_use_res", bus.resultado, 8'h0A);
        check("acc_use_hex", hex, {glifo(4'h0), glifo(4'hA)});
`else
        run_op(T_ADD, 8'd5, 8'd3, 1'b0, lat);
        check("noacc_first_res", bus.resultado, 8'h08);
        run_op(T_ADD, 8'h20, 8'd2, 1'b1, lat);
        check("noacc_ignore_res", bus.resultado, 8'h22);
        check("noacc_ignore_hex", hex, {glifo(4'h2), glifo(4'h2)});
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
